pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Backward-facing control for the 5-stage SPARC pipeline. Consumes rs/rd/enable fields from the ID, EX, MEM and WB pipeline registers.
//  Drives the signals that flow against the pipeline: PC/nPC/IF_ID load enables, ID/EX bubble insert, IF/ID flush and operand forwarding selects.
//  Owns the load-use stall FSM, the data-memory wait freeze, annulled delay-slot squash and a saturating stall counter.
// PARAMETERS
//  CNT_W        16  width of stall_count
//  WAIT_LIMIT   15  consecutive MEM_WAIT cycles before mem_timeout sets (1..255)
// PORTS
//  clk            in   1   clock, rising edge
//  clr            in   1   reset, asynchronous, active-low
//  ID_rs1/ID_rs2  in   5   source regs of instr in ID
//  ID_rd          in   5   store-data reg of instr in ID
//  ID_use_rs1/rs2/rd in 1  field is read by instr in ID
//  ID_annul       in   1   branch in ID is annulling its delay slot
//  EX_rd, EX_we, EX_load  in 5/1/1  dest, RF write, is-load for instr in EX
//  MEM_rd, MEM_we in   5/1 dest, RF write for instr in MEM
//  MEM_memop      in   1   instr in MEM accesses data memory
//  MEM_ready      in   1   data memory completed access this cycle
//  WB_rd, WB_we   in   5/1 dest, RF write for instr in WB
//  PC_LE, nPC_LE, IF_ID_LE  out 1  load enables, 1 = advance
//  ID_EX_nop      out  1   ID/EX loads all-zero control (bubble)
//  IF_ID_flush    out  1   IF/ID loads NOP instead of fetched word
//  EX_MEM_LE, MEM_WB_LE out 1  back-end load enables
//  fwd_rs1/fwd_rs2/fwd_rd out 2  0=RF 1=EX 2=MEM 3=WB
//  stall_count    out  CNT_W  cycles with PC_LE=0, saturating
//  mem_timeout    out  1   sticky: MEM_WAIT reached WAIT_LIMIT
// BEHAVIOUR
//  Register r0 (%g0): rd==0 never matches, forwards or stalls.
//  Forwarding (combinational, same cycle):
//   - Match = use & we & rd==rs & rd!=0.
//   - Priority EX > MEM > WB. EX match with EX_load is not forwarded; it stalls instead.
//  Hazard: load_use = EX_load & EX_we & EX_rd!=0 & EX_rd matches any used ID field.
//  FSM states:
//   RUN:
//    - Default outputs: all LEs=1, nop=0, flush=0.
//    - Priority (a) > (b) > (c).
//    - (a) MEM_memop & !MEM_ready: all five LEs=0, nop=0, flush=0; next MEM_WAIT, wait_cnt=1.
//    - (b) load_use: PC_LE=nPC_LE=IF_ID_LE=0, ID_EX_nop=1, back-end LEs=1; next LSTALL.
//    - (c) ID_annul: IF_ID_flush=1, LEs=1; stays RUN.
//   LSTALL:
//    - One cycle; the load is now in MEM.
//    - Re-evaluates (a) (to MEM_WAIT) and (c); otherwise as RUN default; next RUN.
//    - load_use cannot re-fire: the bubble is in EX.
//   MEM_WAIT:
//    - All LEs=0, nop=0, flush=0 while !MEM_ready; wait_cnt++ saturating at WAIT_LIMIT.
//    - On MEM_ready: outputs as RUN evaluation of the current inputs, same cycle; next RUN.
//    - A load_use found on exit enters LSTALL.
//  Simultaneous events:
//   - Wait freeze beats load_use, which beats annul.
//   - A suppressed annul is not lost: the branch is still held in ID and re-asserts ID_annul.
//  mem_timeout: set when wait_cnt reaches WAIT_LIMIT; cleared only by clr.
//  stall_count: +1 every clk with PC_LE=0; holds at 2^CNT_W-1.
//  Reset (clr=0), asynchronous:
//   - State RUN, stall_count=0, wait_cnt=0, mem_timeout=0.
//   - While clr=0: all LEs=0, ID_EX_nop=1, IF_ID_flush=0, fwd_*=0.
//   - Reset in LSTALL/MEM_WAIT aborts to RUN with no residual stall.
//  Latency: all control outputs are combinational from inputs plus state; state/counters update on rising clk.
// TESTING
//  - EX: rd=5 we=1 load=0; ID: rs1=5 use=1 -> fwd_rs1=1, no stall. Same with MEM only -> 2; WB only -> 3.
//  - EX_rd=MEM_rd=WB_rd=7, all we=1, ID_rs2=7 -> fwd_rs2=1. Repeat with rd=0 -> fwd_rs2=0.
//  - EX load rd=3, ID rs1=3 -> one cycle PC_LE=0, ID_EX_nop=1. Next cycle fwd_rs1=2, LEs=1, stall_count=1.
//  - MEM_memop=1, MEM_ready=0 for 20 cycles -> all LEs=0 throughout. mem_timeout=1 after cycle 15.
//    Ready -> LEs=1 same cycle; stall_count=20.
//  - ID_annul with concurrent load_use -> stall only (flush=0). Next cycle ID_annul -> IF_ID_flush=1.
//  - clr pulled low mid-MEM_WAIT -> LEs=0, nop=1 immediately. After release: RUN, counters 0, LEs=1.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Backward-flowing pipeline control: operand forwarding, load-use stall,
// data-memory wait freeze, annulled delay-slot flush and stall accounting.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// RUN      | normal issue; evaluates freeze > load-use > annul each cycle
// LSTALL   | one-cycle bubble after a load-use stall; load now in MEM
// MEM_WAIT | whole pipe frozen until data memory reports ready
module pipeline_hazard_ctrl #(
   parameter int CNT_W      = 16,
   parameter int WAIT_LIMIT = 15
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [4:0]       ID_rs1,
   input  logic [4:0]       ID_rs2,
   input  logic [4:0]       ID_rd,
   input  logic             ID_use_rs1,
   input  logic             ID_use_rs2,
   input  logic             ID_use_rd,
   input  logic             ID_annul,
   input  logic [4:0]       EX_rd,
   input  logic             EX_we,
   input  logic             EX_load,
   input  logic [4:0]       MEM_rd,
   input  logic             MEM_we,
   input  logic             MEM_memop,
   input  logic             MEM_ready,
   input  logic [4:0]       WB_rd,
   input  logic             WB_we,
   output logic             PC_LE,
   output logic             nPC_LE,
   output logic             IF_ID_LE,
   output logic             ID_EX_nop,
   output logic             IF_ID_flush,
   output logic             EX_MEM_LE,
   output logic             MEM_WB_LE,
   output logic [1:0]       fwd_rs1,
   output logic [1:0]       fwd_rs2,
   output logic [1:0]       fwd_rd,
   output logic [CNT_W-1:0] stall_count,
   output logic             mem_timeout
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LSTALL   = 2'd1,
      MEM_WAIT = 2'd2
   } state_t;

   localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

   state_t     state, state_nxt;
   logic [7:0] wait_cnt, wait_cnt_nxt;
   logic       fe_le, be_le, nop, flush;
   logic       freeze, load_use;
   logic       ex1, ex2, exd, mem1, mem2, memd, wb1, wb2, wbd;
   logic [1:0] sel1, sel2, seld;

   // %g0 never matches, so a zero destination neither forwards nor stalls
   function automatic logic hit(input logic use_f, input logic we,
                                input logic [4:0] rd, input logic [4:0] rs);
      return use_f & we & (rd == rs) & (rd != 5'd0);
   endfunction

   // A load result is not yet available in EX; such a match stalls instead
   function automatic logic [1:0] sel(input logic ex, input logic is_load,
                                      input logic mem, input logic wb);
      if (ex && !is_load) return 2'd1;
      else if (mem)       return 2'd2;
      else if (wb)        return 2'd3;
      else                return 2'd0;
   endfunction

   assign ex1  = hit(ID_use_rs1, EX_we,  EX_rd,  ID_rs1);
   assign ex2  = hit(ID_use_rs2, EX_we,  EX_rd,  ID_rs2);
   assign exd  = hit(ID_use_rd,  EX_we,  EX_rd,  ID_rd);
   assign mem1 = hit(ID_use_rs1, MEM_we, MEM_rd, ID_rs1);
   assign mem2 = hit(ID_use_rs2, MEM_we, MEM_rd, ID_rs2);
   assign memd = hit(ID_use_rd,  MEM_we, MEM_rd, ID_rd);
   assign wb1  = hit(ID_use_rs1, WB_we,  WB_rd,  ID_rs1);
   assign wb2  = hit(ID_use_rs2, WB_we,  WB_rd,  ID_rs2);
   assign wbd  = hit(ID_use_rd,  WB_we,  WB_rd,  ID_rd);

   assign sel1 = sel(ex1, EX_load, mem1, wb1);
   assign sel2 = sel(ex2, EX_load, mem2, wb2);
   assign seld = sel(exd, EX_load, memd, wbd);

   assign load_use = EX_load & (ex1 | ex2 | exd);
   assign freeze   = MEM_memop & ~MEM_ready;

   always_comb begin
      state_nxt = state;
      fe_le     = 1'b1;
      be_le     = 1'b1;
      nop       = 1'b0;
      flush     = 1'b0;
      case (state)
         RUN: begin
            if (freeze) begin
               fe_le     = 1'b0;
               be_le     = 1'b0;
               state_nxt = MEM_WAIT;
            end else if (load_use) begin
               fe_le     = 1'b0;
               nop       = 1'b1;
               state_nxt = LSTALL;
            end else if (ID_annul) begin
               flush = 1'b1;
            end
         end
         LSTALL: begin
            state_nxt = RUN;
            if (freeze) begin
               fe_le     = 1'b0;
               be_le     = 1'b0;
               state_nxt = MEM_WAIT;
            end else if (ID_annul) begin
               flush = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (freeze) begin
               fe_le = 1'b0;
               be_le = 1'b0;
            end else begin
               state_nxt = RUN;
               if (load_use) begin
                  fe_le     = 1'b0;
                  nop       = 1'b1;
                  state_nxt = LSTALL;
               end else if (ID_annul) begin
                  flush = 1'b1;
               end
            end
         end
         default: state_nxt = RUN;
      endcase
      // Held reset keeps the pipe still and bubbles ID/EX
      if (!clr) begin
         fe_le = 1'b0;
         be_le = 1'b0;
         nop   = 1'b1;
         flush = 1'b0;
      end
   end

   always_comb begin
      wait_cnt_nxt = 8'd0;
      if (state_nxt == MEM_WAIT) begin
         if (state != MEM_WAIT)      wait_cnt_nxt = 8'd1;
         else if (wait_cnt >= LIMIT) wait_cnt_nxt = LIMIT;
         else                        wait_cnt_nxt = wait_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state       <= RUN;
         wait_cnt    <= 8'd0;
         mem_timeout <= 1'b0;
         stall_count <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         if (wait_cnt_nxt == LIMIT)
            mem_timeout <= 1'b1;
         if (!fe_le && (stall_count != '1))
            stall_count <= stall_count + CNT_W'(1);
      end
   end

   assign PC_LE       = fe_le;
   assign nPC_LE      = fe_le;
   assign IF_ID_LE    = fe_le;
   assign EX_MEM_LE   = be_le;
   assign MEM_WB_LE   = be_le;
   assign ID_EX_nop   = nop;
   assign IF_ID_flush = flush;
   assign fwd_rs1     = clr ? sel1 : 2'd0;
   assign fwd_rs2     = clr ? sel2 : 2'd0;
   assign fwd_rd      = clr ? seld : 2'd0;

endmodule
